// File: rtl/ifetch_wb_master_if.sv
// ifetch_wb_master_if
//  Bundles the decode-side fetch handshake and the instruction Wishbone
//  (i*-prefixed) bus of the fetch unit.
//  master : the fetch unit (drives Wishbone requests and the inst_* outputs)
//  slave  : decode + instruction BRAM side (drives controls, ack/err/data)
//  Signals:
//   fetch_en_i, redirect_i, redirect_pc_i, inst_ready_i : fetch control in
//   inst_valid_o, inst_o, inst_pc_o, fault_o            : fetched word / status
//   iaddr_o, idat_o, isel_o, icyc_o, istb_o, iwe_o      : Wishbone request
//   idat_i, iack_i, ierr_i                              : Wishbone response
interface ifetch_wb_master_if;
  logic        fetch_en_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        inst_ready_i;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        fault_o;
  logic [31:0] iaddr_o;
  logic [31:0] idat_o;
  logic        isel_o;
  logic        icyc_o;
  logic        istb_o;
  logic        iwe_o;
  logic [31:0] idat_i;
  logic        iack_i;
  logic        ierr_i;

  modport master (
    input  fetch_en_i, redirect_i, redirect_pc_i, inst_ready_i,
    output inst_valid_o, inst_o, inst_pc_o, fault_o,
    output iaddr_o, idat_o, isel_o, icyc_o, istb_o, iwe_o,
    input  idat_i, iack_i, ierr_i
  );

  modport slave (
    output fetch_en_i, redirect_i, redirect_pc_i, inst_ready_i,
    input  inst_valid_o, inst_o, inst_pc_o, fault_o,
    input  iaddr_o, idat_o, isel_o, icyc_o, istb_o, iwe_o,
    output idat_i, iack_i, ierr_i
  );
endinterface

// File: rtl/ifetch_wb_master.sv
// ifetch_wb_master
//  Instruction-fetch initiator on the instruction Wishbone port. Issues
//  single-word reads, tracks the PC, hands words to decode over valid/ready,
//  and handles branch redirects and bus errors. One bus cycle outstanding.
//  Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : ifetch_wb_master_if.master (fetch control, inst_* outputs, Wishbone)
//  Optional feature macro: IFETCH_TIMEOUT_EN -- abort a REQ that sees no
//  ack/err within TIMEOUT_CYCLES cycles and enter FAULT.
module ifetch_wb_master #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned PC_STEP        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input logic               clk,
  input logic               rst,
  ifetch_wb_master_if.master bus
);
  typedef enum logic [1:0] {IDLE, REQ, VALID, FAULT} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        rd_pend_q, rd_pend_d;
  logic [31:0] rd_pc_q, rd_pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  // Low for one cycle after reset release and after a discarded ack, so the
  // strobe (driven combinationally from IDLE) always has a gap after an ack.
  logic        issue_ok_q, issue_ok_d;
  logic        issue;
  logic [31:0] tgt;

  assign tgt = {bus.redirect_pc_i[31:2], 2'b00};

`ifdef IFETCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    rd_pend_d  = rd_pend_q;
    rd_pc_d    = rd_pc_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    valid_d    = valid_q;
    fault_d    = fault_q;
    issue_ok_d = 1'b1;
    issue      = 1'b0;
`ifdef IFETCH_TIMEOUT_EN
    tmo_d      = tmo_q;
`endif
    case (state_q)
      IDLE: begin
        // A redirect here only moves the PC; the fetch starts next cycle.
        if (bus.redirect_i) begin
          pc_d = tgt;
        end else if (issue_ok_q && bus.fetch_en_i) begin
          issue   = 1'b1;
          state_d = REQ;
`ifdef IFETCH_TIMEOUT_EN
          tmo_d   = '0;
`endif
        end
      end
      REQ: begin
        if (bus.ierr_i) begin
          fault_d   = 1'b1;
          rd_pend_d = 1'b0;
          state_d   = FAULT;
        end else if (bus.iack_i) begin
          if (rd_pend_q || bus.redirect_i) begin
            pc_d       = bus.redirect_i ? tgt : rd_pc_q;
            rd_pend_d  = 1'b0;
            issue_ok_d = 1'b0;
            state_d    = IDLE;
          end else begin
            inst_d    = bus.idat_i;
            inst_pc_d = pc_q;
            valid_d   = 1'b1;
            pc_d      = pc_q + 32'(PC_STEP);
            state_d   = VALID;
          end
        end else begin
          // Never abort a cycle mid-flight; remember the target instead.
          if (bus.redirect_i) begin
            rd_pend_d = 1'b1;
            rd_pc_d   = tgt;
          end
`ifdef IFETCH_TIMEOUT_EN
          if (tmo_q == TMO_LAST) begin
            fault_d   = 1'b1;
            rd_pend_d = 1'b0;
            state_d   = FAULT;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
`endif
        end
      end
      VALID: begin
        if (bus.redirect_i) begin
          valid_d = 1'b0;
          pc_d    = tgt;
          state_d = IDLE;
        end else if (bus.inst_ready_i) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      FAULT: begin
        if (bus.redirect_i) begin
          fault_d = 1'b0;
          pc_d    = tgt;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      rd_pend_q  <= 1'b0;
      rd_pc_q    <= '0;
      inst_q     <= '0;
      inst_pc_q  <= '0;
      valid_q    <= 1'b0;
      fault_q    <= 1'b0;
      issue_ok_q <= 1'b0;
`ifdef IFETCH_TIMEOUT_EN
      tmo_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      rd_pend_q  <= rd_pend_d;
      rd_pc_q    <= rd_pc_d;
      inst_q     <= inst_d;
      inst_pc_q  <= inst_pc_d;
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      issue_ok_q <= issue_ok_d;
`ifdef IFETCH_TIMEOUT_EN
      tmo_q      <= tmo_d;
`endif
    end
  end

  logic cyc;
  // issue_ok_q is 0 while rst is high, so the strobe drops at once on reset.
  assign cyc = issue || (state_q == REQ);

  assign bus.icyc_o       = cyc;
  assign bus.istb_o       = cyc;
  assign bus.isel_o       = cyc;
  assign bus.iwe_o        = 1'b0;
  assign bus.idat_o       = 32'h0;
  assign bus.iaddr_o      = pc_q;
  assign bus.inst_valid_o = valid_q;
  assign bus.inst_o       = inst_q;
  assign bus.inst_pc_o    = inst_pc_q;
  assign bus.fault_o      = fault_q;
endmodule

// File: tb/tb_ifetch_wb_master.sv
module tb_ifetch_wb_master;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ifetch_wb_master_if bus();

  ifetch_wb_master #(
    .RESET_PC(32'h0000_0000), .PC_STEP(4), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;
  int n_starts = 0;
  logic [31:0] addr_q[$];
  logic [63:0] inst_q[$];

  // Responder controls
  int          lat = 0;
  bit          noack = 1'b0;
  bit          err_en = 1'b0;
  logic [31:0] err_addr = 32'h0;
  int          bcnt;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event missing or unexpected", nm);
  endtask

  // Instruction BRAM: word at address a is {~a[15:0], a[15:0]}, ack after lat+1 cycles.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.iack_i <= 1'b0;
      bus.ierr_i <= 1'b0;
      bus.idat_i <= 32'h0;
      bcnt       <= 0;
    end else if (bus.iack_i || bus.ierr_i) begin
      bus.iack_i <= 1'b0;
      bus.ierr_i <= 1'b0;
    end else if (bus.istb_o && !noack) begin
      if (bcnt >= lat) begin
        bcnt <= 0;
        if (err_en && bus.iaddr_o == err_addr) bus.ierr_i <= 1'b1;
        else begin
          bus.iack_i <= 1'b1;
          bus.idat_i <= {~bus.iaddr_o[15:0], bus.iaddr_o[15:0]};
        end
      end else bcnt <= bcnt + 1;
    end
  end

  // Monitor: bus cycle starts and decode handshakes are checked against queues.
  bit prev_stb, prev_ack;
  always @(negedge clk) begin
    if (rst) begin
      prev_stb = 1'b0;
      prev_ack = 1'b0;
    end else begin
      if (prev_ack) check("stb_gap_after_ack", 32'(bus.istb_o), 32'h0);
      if (bus.istb_o && !prev_stb) begin
        n_starts++;
        if (addr_q.size() == 0) fail("unexpected_bus_cycle");
        else check("fetch_addr", bus.iaddr_o, addr_q.pop_front());
        check("sel_cyc_at_start", {30'h0, bus.isel_o, bus.icyc_o}, 32'h3);
        check("we_dat_zero", {bus.idat_o[30:0], bus.iwe_o}, 32'h0);
      end
      if (bus.inst_valid_o && bus.inst_ready_i) begin
        if (inst_q.size() == 0) fail("unexpected_inst");
        else begin
          logic [63:0] e;
          e = inst_q.pop_front();
          check("inst_pc", bus.inst_pc_o, e[63:32]);
          check("inst_data", bus.inst_o, e[31:0]);
        end
      end
      prev_ack = bus.istb_o && bus.iack_i;
      prev_stb = bus.istb_o;
    end
  end

  task automatic wait_starts(input int t);
    int k = 0;
    while (n_starts < t && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    if (n_starts < t) fail("wait_bus_cycle_timeout");
  endtask

  task automatic drain();
    int k = 0;
    while (inst_q.size() != 0 && k < 200) begin
      @(negedge clk); #1;
      k++;
    end
    if (inst_q.size() != 0) fail("wait_inst_timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic stop_after_issue();
    @(posedge clk); #1;
    bus.fetch_en_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.fetch_en_i    = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.inst_ready_i  = 1'b0;
    rst = 1'b1;

    // Reset state; fetch_en must not start a cycle while in reset
    repeat (2) @(negedge clk);
    bus.fetch_en_i = 1'b1;
    #1;
    check("rst_icyc", 32'(bus.icyc_o), 32'h0);
    check("rst_istb", 32'(bus.istb_o), 32'h0);
    check("rst_valid", 32'(bus.inst_valid_o), 32'h0);
    check("rst_fault", 32'(bus.fault_o), 32'h0);
    check("rst_iaddr", bus.iaddr_o, 32'h0);
    bus.fetch_en_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;

    // Sequential fetch, decode always ready
    addr_q.push_back(32'h0);  inst_q.push_back({32'h0,  32'hFFFF_0000});
    addr_q.push_back(32'h4);  inst_q.push_back({32'h4,  32'hFFFB_0004});
    addr_q.push_back(32'h8);  inst_q.push_back({32'h8,  32'hFFF7_0008});
    addr_q.push_back(32'hC);  inst_q.push_back({32'hC,  32'hFFF3_000C});
    bus.inst_ready_i = 1'b1;
    bus.fetch_en_i   = 1'b1;
    wait_starts(4);
    stop_after_issue();
    drain();

    // Decode stall: word held stable, no new bus cycle until accepted
    addr_q.push_back(32'h10); inst_q.push_back({32'h10, 32'hFFEF_0010});
    addr_q.push_back(32'h14); inst_q.push_back({32'h14, 32'hFFEB_0014});
    bus.inst_ready_i = 1'b0;
    bus.fetch_en_i   = 1'b1;
    begin
      int k = 0;
      while (!bus.inst_valid_o && k < 50) begin @(negedge clk); #1; k++; end
      if (!bus.inst_valid_o) fail("stall_valid_timeout");
    end
    repeat (5) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.inst_valid_o), 32'h1);
      check("stall_inst", bus.inst_o, 32'hFFEF_0010);
      check("stall_pc", bus.inst_pc_o, 32'h10);
      check("stall_no_cyc", 32'(bus.icyc_o), 32'h0);
    end
    @(posedge clk); #1;
    bus.inst_ready_i = 1'b1;
    wait_starts(6);
    stop_after_issue();
    drain();

    // Redirect during a slow REQ: the acked word at 0x18 is discarded
    lat = 2;
    addr_q.push_back(32'h18);
    addr_q.push_back(32'h40); inst_q.push_back({32'h40, 32'hFFBF_0040});
    bus.fetch_en_i = 1'b1;
    wait_starts(7);
    @(posedge clk); #1;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_0043;
    @(posedge clk); #1;
    bus.redirect_i = 1'b0;
    wait_starts(8);
    stop_after_issue();
    drain();
    lat = 0;

    // Bus error: fault, no further cycles, redirect recovers
    err_en   = 1'b1;
    err_addr = 32'h44;
    addr_q.push_back(32'h44);
    bus.fetch_en_i = 1'b1;
    begin
      int k = 0;
      while (!bus.fault_o && k < 50) begin @(negedge clk); #1; k++; end
      if (!bus.fault_o) fail("fault_timeout");
    end
    repeat (4) begin
      @(negedge clk);
      check("fault_level", 32'(bus.fault_o), 32'h1);
      check("fault_no_cyc", 32'(bus.icyc_o), 32'h0);
      check("fault_no_valid", 32'(bus.inst_valid_o), 32'h0);
    end
    err_en = 1'b0;
    addr_q.push_back(32'h0); inst_q.push_back({32'h0, 32'hFFFF_0000});
    @(posedge clk); #1;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0;
    @(posedge clk); #1;
    bus.redirect_i = 1'b0;
    @(negedge clk); #1;
    check("fault_cleared", 32'(bus.fault_o), 32'h0);
    wait_starts(10);
    stop_after_issue();
    drain();

    // Reset in the middle of a bus cycle
    lat = 3;
    addr_q.push_back(32'h4);
    bus.fetch_en_i = 1'b1;
    wait_starts(11);
    @(posedge clk); #1;
    check("pre_rst_stb", 32'(bus.istb_o), 32'h1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_icyc", 32'(bus.icyc_o), 32'h0);
    check("mid_rst_istb", 32'(bus.istb_o), 32'h0);
    check("mid_rst_valid", 32'(bus.inst_valid_o), 32'h0);
    lat = 0;
    addr_q.push_back(32'h0); inst_q.push_back({32'h0, 32'hFFFF_0000});
    @(posedge clk); #1;
    rst = 1'b0;
    wait_starts(12);
    stop_after_issue();
    drain();

    // Responder that never acknowledges
    noack = 1'b1;
    addr_q.push_back(32'h4);
    bus.fetch_en_i = 1'b1;
    wait_starts(13);
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
`ifdef IFETCH_TIMEOUT_EN
      check("tmo_stb", 32'(bus.istb_o), (n < 16) ? 32'h1 : 32'h0);
      check("tmo_fault", 32'(bus.fault_o), (n < 16) ? 32'h0 : 32'h1);
`else
      check("noack_stb_held", 32'(bus.istb_o), 32'h1);
      check("noack_no_fault", 32'(bus.fault_o), 32'h0);
`endif
    end
    bus.fetch_en_i = 1'b0;

    check("addr_queue_empty", 32'(addr_q.size()), 32'h0);
    check("inst_queue_empty", 32'(inst_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
